seed_decrypt: RTL and testbench



---
 rtl/seed_pkg.sv | 83 ++++++++
 rtl/seed_g.sv | 44 ++++
 rtl/seed_decrypt.sv | 133 +++++++++++++
 tb/tb_seed_decrypt.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seed_pkg.sv
// Shared types, constants and helpers for the SEED decryptor datapath.
`default_nettype none

package seed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] KC16    = 32'hbcdccf1b;
  localparam int          STEP_W  = 3;
  localparam int          ROUND_W = 4;
  localparam logic [STEP_W-1:0]  LAST_STEP  = 3'd4;
  localparam logic [ROUND_W-1:0] LAST_ROUND = 4'd15;

  localparam logic [7:0] M0 = 8'hfc;
  localparam logic [7:0] M1 = 8'hf3;
  localparam logic [7:0] M2 = 8'hcf;
  localparam logic [7:0] M3 = 8'h3f;

  localparam int S1 [256] = '{
    169, 133, 214, 211,  84,  29, 172,  37,  93,  67,  24,  30,  81, 252, 202,  99,
     40,  68,  32, 157, 224, 226, 200,  23, 165, 143,   3, 123, 187,  19, 210, 238,
    112, 140,  63, 168,  50, 221, 246, 116, 236, 149,  11,  87,  92,  91, 189,   1,
     36,  28, 115, 152,  16, 204, 242, 217,  44, 231, 114, 131, 155, 209, 134, 201,
     96,  80, 163, 235,  13, 182, 158,  79, 183,  90, 198, 120, 166,  18, 175, 213,
     97, 195, 180,  65,  82, 125, 141,   8,  31, 153,   0,  25,   4,  83, 247, 225,
    253, 118,  47,  39, 176, 139,  14, 171, 162, 110, 147,  77, 105, 124,   9,  10,
    191, 239, 243, 197, 135,  20, 254, 100, 222,  46,  75,  26,   6,  33, 107, 102,
      2, 245, 146, 138,  12, 179, 126, 208, 122,  71, 150, 229,  38, 128, 173, 223,
    161,  48,  55, 174,  54,  21,  34,  56, 244, 167,  69,  76, 129, 233, 132, 151,
     53, 203, 206,  60, 113,  17, 199, 137, 117, 251, 218, 248, 148,  89, 130, 196,
    255,  73,  57, 103, 192, 207, 215, 184,  15, 142,  66,  35, 145, 108, 219, 164,
     52, 241,  72, 194, 111,  61,  45,  64, 190,  62, 188, 193, 170, 186,  78,  85,
     59, 220, 104, 127, 156, 216,  74,  86, 119, 160, 237,  70, 181,  43, 101, 250,
    227, 185, 177, 159,  94, 249, 230, 178,  49, 234, 109,  95, 228, 240, 205, 136,
     22,  58,  88, 212,  98,  41,   7,  51, 232,  27,   5, 121, 144, 106,  42, 154
  };

  localparam int S2 [256] = '{
     56, 232,  45, 166, 207, 222, 179, 184, 175,  96,  85, 199,  68, 111, 107,  91,
    195,  98,  51, 181,  41, 160, 226, 167, 211, 145,  17,   6,  28, 188,  54,  75,
    239, 136, 108, 168,  23, 196,  22, 244, 194,  69, 225, 214,  63,  61, 142, 152,
     40,  78, 246,  62, 165, 249,  13, 223, 216,  43, 102, 122,  39,  47, 241, 114,
     66, 212,  65, 192, 115, 103, 172, 139, 247, 173, 128,  31, 202,  44, 170,  52,
    210,  11, 238, 233,  93, 148,  24, 248,  87, 174,   8, 197,  19, 205, 134, 185,
    255, 125, 193,  49, 245, 138, 106, 177, 209,  32, 215,   2,  34,   4, 104, 113,
      7, 219, 157, 153,  97, 190, 230,  89, 221,  81, 144, 220, 154, 163, 171, 208,
    129,  15,  71,  26, 227, 236, 141, 191, 150, 123,  92, 162, 161,  99,  35,  77,
    200, 158, 156,  58,  12,  46, 186, 110, 159,  90, 242, 146, 243,  73, 120, 204,
     21, 251, 112, 117, 127,  53,  16,   3, 100, 109, 198, 116, 213, 180, 234,   9,
    118,  25, 254,  64,  18, 224, 189,   5, 250,   1, 240,  42,  94, 169,  86,  67,
    133,  20, 137, 155, 176, 229,  72, 121, 151, 252,  30, 130,  33, 140,  27,  95,
    119,  84, 178,  29,  37,  79,   0,  70, 237,  88,  82, 235, 126, 218, 201, 253,
     48, 149, 101,  60, 182, 228, 187, 124,  14,  80,  57,  38,  50, 132, 105, 147,
     55, 231,  36, 164, 203,  83,  10, 135, 217,  76, 131, 143, 206,  59,  74, 183
  };

  function automatic logic [7:0] sbox1(input logic [7:0] x);
    return 8'(S1[x]);
  endfunction

  function automatic logic [7:0] sbox2(input logic [7:0] x);
    return 8'(S2[x]);
  endfunction

  function automatic logic [63:0] rotl64_8(input logic [63:0] x);
    return {x[55:0], x[63:56]};
  endfunction

  function automatic logic [63:0] rotr64_8(input logic [63:0] x);
    return {x[7:0], x[63:8]};
  endfunction

  function automatic logic [31:0] rotr32_1(input logic [31:0] x);
    return {x[0], x[31:1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/seed_g.sv
// SEED G-function: four masked S-box lookups (SS0..SS3) XORed together.
`default_nettype none

module seed_ss
  import seed_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic [7:0]  x,
  output logic [31:0] y
);

  logic [7:0] s;

  // Even tables derive from S1, odd tables from S2; the byte-mask order rotates per table.
  always_comb begin
    s = (IDX % 2 == 0) ? sbox1(x) : sbox2(x);
    case (IDX)
      0:       y = {s & M3, s & M2, s & M1, s & M0};
      1:       y = {s & M0, s & M3, s & M2, s & M1};
      2:       y = {s & M1, s & M0, s & M3, s & M2};
      default: y = {s & M2, s & M1, s & M0, s & M3};
    endcase
  end

endmodule

module seed_g (
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic [31:0] y0, y1, y2, y3;

  seed_ss #(.IDX(0)) ss0 (.x(x[7:0]),   .y(y0));
  seed_ss #(.IDX(1)) ss1 (.x(x[15:8]),  .y(y1));
  seed_ss #(.IDX(2)) ss2 (.x(x[23:16]), .y(y2));
  seed_ss #(.IDX(3)) ss3 (.x(x[31:24]), .y(y3));

  assign y = y0 ^ y1 ^ y2 ^ y3;

endmodule

`default_nettype wire

// File: rtl/seed_decrypt.sv
// Iterative SEED block decryptor: 16 rounds x 5 steps through one shared G-function,
// with the key schedule walked backwards from round 16.
`default_nettype none

module seed_decrypt
  import seed_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_i,
  input  logic [127:0] ct_i,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] pt_o,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t state, state_nxt;

  logic [STEP_W-1:0]  step;
  logic [ROUND_W-1:0] rnd;
  logic [63:0]        l, r, ab, cd;
  logic [31:0]        kc, k0, k1, t0, t1;
  logic [31:0]        g_in, g_out;
  logic [31:0]        t0_s2;
  logic [63:0]        r_new;
  logic               accept;
  logic               last_step;

  assign accept    = (state == ST_IDLE) && in_valid && in_ready;
  assign last_step = (step == LAST_STEP);
  assign t0_s2     = r[63:32] ^ k0;
  assign r_new     = l ^ {t0 + g_out, g_out};

  always_comb begin
    g_in = '0;
    if (state == ST_ROUND) begin
      case (step)
        3'd0:    g_in = ab[63:32] + cd[63:32] - kc;
        3'd1:    g_in = ab[31:0] - cd[31:0] + kc;
        3'd2:    g_in = t0_s2 ^ r[31:0] ^ k1;
        3'd3:    g_in = t0 + t1;
        3'd4:    g_in = t1 + t0;
        default: g_in = '0;
      endcase
    end
  end

  seed_g g_fn (.x(g_in), .y(g_out));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ROUND;
      ST_ROUND: if (last_step && rnd == LAST_ROUND) state_nxt = ST_DONE;
      ST_DONE:  if (out_valid && out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step      <= '0;
      rnd       <= '0;
      l         <= '0;
      r         <= '0;
      ab        <= '0;
      cd        <= '0;
      kc        <= '0;
      k0        <= '0;
      k1        <= '0;
      t0        <= '0;
      t1        <= '0;
      pt_o      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      in_ready <= (state_nxt == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            l    <= ct_i[127:64];
            r    <= ct_i[63:0];
            ab   <= key_i[127:64];
            cd   <= rotr64_8(key_i[63:0]);
            kc   <= KC16;
            step <= '0;
            rnd  <= '0;
          end
        end
        ST_ROUND: begin
          step <= last_step ? '0 : step + 3'd1;
          case (step)
            3'd0: k0 <= g_out;
            3'd1: k1 <= g_out;
            3'd2: begin
              t0 <= t0_s2;
              t1 <= g_out;
            end
            3'd3: t0 <= g_out;
            3'd4: begin
              l   <= r;
              r   <= r_new;
              // Round counter even means the previous encrypt round (16 - rnd - 1) is odd.
              if (!rnd[0]) ab <= rotl64_8(ab);
              else         cd <= rotr64_8(cd);
              kc  <= rotr32_1(kc);
              rnd <= rnd + 4'd1;
              if (rnd == LAST_ROUND) begin
                pt_o      <= {r_new, r};
                out_valid <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        ST_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seed_decrypt.sv
// Directed and randomized checks of seed_decrypt against a SEED encryption model.
`default_nettype none

module tb_seed_decrypt;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_i, ct_i, pt_o;
  logic         in_valid, in_ready, out_valid, out_ready;

  int vecs = 0;
  int errs = 0;

  seed_decrypt dut (
    .clk(clk), .rst_n(rst_n), .key_i(key_i), .ct_i(ct_i),
    .in_valid(in_valid), .in_ready(in_ready),
    .pt_o(pt_o), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  localparam int TS1 [256] = '{
    169, 133, 214, 211,  84,  29, 172,  37,  93,  67,  24,  30,  81, 252, 202,  99,
     40,  68,  32, 157, 224, 226, 200,  23, 165, 143,   3, 123, 187,  19, 210, 238,
    112, 140,  63, 168,  50, 221, 246, 116, 236, 149,  11,  87,  92,  91, 189,   1,
     36,  28, 115, 152,  16, 204, 242, 217,  44, 231, 114, 131, 155, 209, 134, 201,
     96,  80, 163, 235,  13, 182, 158,  79, 183,  90, 198, 120, 166,  18, 175, 213,
     97, 195, 180,  65,  82, 125, 141,   8,  31, 153,   0,  25,   4,  83, 247, 225,
    253, 118,  47,  39, 176, 139,  14, 171, 162, 110, 147,  77, 105, 124,   9,  10,
    191, 239, 243, 197, 135,  20, 254, 100, 222,  46,  75,  26,   6,  33, 107, 102,
      2, 245, 146, 138,  12, 179, 126, 208, 122,  71, 150, 229,  38, 128, 173, 223,
    161,  48,  55, 174,  54,  21,  34,  56, 244, 167,  69,  76, 129, 233, 132, 151,
     53, 203, 206,  60, 113,  17, 199, 137, 117, 251, 218, 248, 148,  89, 130, 196,
    255,  73,  57, 103, 192, 207, 215, 184,  15, 142,  66,  35, 145, 108, 219, 164,
     52, 241,  72, 194, 111,  61,  45,  64, 190,  62, 188, 193, 170, 186,  78,  85,
     59, 220, 104, 127, 156, 216,  74,  86, 119, 160, 237,  70, 181,  43, 101, 250,
    227, 185, 177, 159,  94, 249, 230, 178,  49, 234, 109,  95, 228, 240, 205, 136,
     22,  58,  88, 212,  98,  41,   7,  51, 232,  27,   5, 121, 144, 106,  42, 154
  };

  localparam int TS2 [256] = '{
     56, 232,  45, 166, 207, 222, 179, 184, 175,  96,  85, 199,  68, 111, 107,  91,
    195,  98,  51, 181,  41, 160, 226, 167, 211, 145,  17,   6,  28, 188,  54,  75,
    239, 136, 108, 168,  23, 196,  22, 244, 194,  69, 225, 214,  63,  61, 142, 152,
     40,  78, 246,  62, 165, 249,  13, 223, 216,  43, 102, 122,  39,  47, 241, 114,
     66, 212,  65, 192, 115, 103, 172, 139, 247, 173, 128,  31, 202,  44, 170,  52,
    210,  11, 238, 233,  93, 148,  24, 248,  87, 174,   8, 197,  19, 205, 134, 185,
    255, 125, 193,  49, 245, 138, 106, 177, 209,  32, 215,   2,  34,   4, 104, 113,
      7, 219, 157, 153,  97, 190, 230,  89, 221,  81, 144, 220, 154, 163, 171, 208,
    129,  15,  71,  26, 227, 236, 141, 191, 150, 123,  92, 162, 161,  99,  35,  77,
    200, 158, 156,  58,  12,  46, 186, 110, 159,  90, 242, 146, 243,  73, 120, 204,
     21, 251, 112, 117, 127,  53,  16,   3, 100, 109, 198, 116, 213, 180, 234,   9,
    118,  25, 254,  64,  18, 224, 189,   5, 250,   1, 240,  42,  94, 169,  86,  67,
    133,  20, 137, 155, 176, 229,  72, 121, 151, 252,  30, 130,  33, 140,  27,  95,
    119,  84, 178,  29,  37,  79,   0,  70, 237,  88,  82, 235, 126, 218, 201, 253,
     48, 149, 101,  60, 182, 228, 187, 124,  14,  80,  57,  38,  50, 132, 105, 147,
     55, 231,  36, 164, 203,  83,  10, 135, 217,  76, 131, 143, 206,  59,  74, 183
  };

  // RFC-form G: S-box the four bytes, then mix with the rotating masks.
  function automatic logic [31:0] g(input logic [31:0] x);
    logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
    y0 = 8'(TS1[x[7:0]]);
    y1 = 8'(TS2[x[15:8]]);
    y2 = 8'(TS1[x[23:16]]);
    y3 = 8'(TS2[x[31:24]]);
    z3 = (y0 & 8'h3f) ^ (y1 & 8'hfc) ^ (y2 & 8'hf3) ^ (y3 & 8'hcf);
    z2 = (y0 & 8'hcf) ^ (y1 & 8'h3f) ^ (y2 & 8'hfc) ^ (y3 & 8'hf3);
    z1 = (y0 & 8'hf3) ^ (y1 & 8'hcf) ^ (y2 & 8'h3f) ^ (y3 & 8'hfc);
    z0 = (y0 & 8'hfc) ^ (y1 & 8'hf3) ^ (y2 & 8'hcf) ^ (y3 & 8'h3f);
    return {z3, z2, z1, z0};
  endfunction

  function automatic logic [63:0] rot64(input logic [63:0] x, input int right);
    return right ? ((x >> 8) | (x << 56)) : ((x << 8) | (x >> 56));
  endfunction

  // Forward SEED encryption; the DUT must invert it.
  function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt);
    logic [63:0] ab, cd, lh, rh, tmp;
    logic [31:0] kc, k0, k1, c0, d0, x, y, z;
    ab = key[127:64];
    cd = key[63:0];
    kc = 32'h9e3779b9;
    lh = pt[127:64];
    rh = pt[63:0];
    for (int i = 1; i <= 16; i++) begin
      k0  = g(ab[63:32] + cd[63:32] - kc);
      k1  = g(ab[31:0] - cd[31:0] + kc);
      c0  = rh[63:32] ^ k0;
      d0  = rh[31:0] ^ k1;
      x   = g(c0 ^ d0);
      y   = g(x + c0);
      z   = g(y + x);
      tmp = lh ^ {z + y, z};
      lh  = rh;
      rh  = tmp;
      if (i % 2 == 1) ab = rot64(ab, 1);
      else            cd = rot64(cd, 0);
      kc = (kc << 1) | (kc >> 31);
    end
    return {rh, lh};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [127:0] key, input logic [127:0] ct,
                           input logic [127:0] exp, input int stall, input string tag);
    int n;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    key_i     = key;
    ct_i      = ct;
    n = 0;
    while (!in_ready && n < 300) begin tick(); n++; end
    check({tag, " in_ready"}, 136'(in_ready), 136'd1);
    tick();
    in_valid = 1'b0;
    key_i    = rand128();
    ct_i     = rand128();
    n = 0;
    while (!out_valid && n < 300) begin tick(); n++; end
    check({tag, " latency"}, 136'(n), 136'd80);
    check({tag, " pt"}, 136'(pt_o), 136'(exp));
    check({tag, " kc end"}, 136'(dut.kc), 136'(32'hcf1bbcdc));
    check({tag, " key state"}, 136'({dut.ab, dut.cd}), 136'({key[127:64], rot64(key[63:0], 1)}));
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, " stall"}, 136'({out_valid, in_ready, pt_o}), 136'({1'b1, 1'b0, exp}));
    end
    out_ready = 1'b1;
    tick();
    check({tag, " release"}, 136'({out_valid, in_ready, pt_o}), 136'({1'b0, 1'b1, exp}));
    out_ready = 1'b0;
  endtask

  logic [127:0] exp_q[$];
  logic [127:0] k, p, e;
  int           acc, pops, cyc, last_acc;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    key_i     = rand128();
    ct_i      = rand128();
    repeat (3) tick();
    check("reset", 136'({out_valid, in_ready, pt_o}), 136'({1'b0, 1'b1, 128'd0}));
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();

    run_block(128'd0, 128'h5EBAC6E0054E166819AFF1CC6D346CDB,
              128'h000102030405060708090A0B0C0D0E0F, 0, "v1");
    run_block(128'h000102030405060708090A0B0C0D0E0F, 128'hC11F22F20140505084483597E4370F43,
              128'd0, 2, "v2");
    run_block(128'h4706480851E61BE85D74BFB3FD956185, 128'hEE54D13EBCAE706D226BC3142CD40D4A,
              128'h83A2F8A288641FB9A4E9A5CC2F131C7D, 20, "v3 backpressure");
    run_block(128'h28DBC3BC49FFD87DCFA509B11D422BE7, 128'h9B9B7BFCD1813CB95D0B3618F40F5122,
              128'hB41E6BE2EBA84A148E2EED84593C5EC7, 1, "v4");

    for (int i = 0; i < 6; i++) begin
      k = rand128();
      p = rand128();
      run_block(k, enc(k, p), p, int'($urandom_range(0, 3)), "random");
    end

    // Abort in round 7, with in_valid asserted during reset.
    in_valid = 1'b1;
    key_i    = 128'd0;
    ct_i     = 128'h5EBAC6E0054E166819AFF1CC6D346CDB;
    tick();
    in_valid = 1'b0;
    repeat (37) tick();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    tick();
    check("mid reset", 136'({out_valid, in_ready, pt_o}), 136'({1'b0, 1'b1, 128'd0}));
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    run_block(128'd0, 128'h5EBAC6E0054E166819AFF1CC6D346CDB,
              128'h000102030405060708090A0B0C0D0E0F, 0, "v1 after reset");

    // in_valid held high with inputs changing every cycle.
    acc = 0; pops = 0; cyc = 0; last_acc = 0;
    out_ready = 1'b1;
    while (pops < 3 && cyc < 1000) begin
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : ~pt_o;
        check("stream pt", 136'(pt_o), 136'(e));
        pops++;
      end
      if (acc < 3) begin
        k = rand128();
        p = rand128();
        key_i    = k;
        ct_i     = enc(k, p);
        in_valid = 1'b1;
        if (in_ready) begin
          if (acc > 0) check("stream spacing", 136'(cyc - last_acc >= 81), 136'd1);
          exp_q.push_back(p);
          last_acc = cyc;
          acc++;
        end
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    check("stream outputs", 136'(pops), 136'd3);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
